pwm_bridge_driver: RTL and testbench
====================================

Name: pwm_bridge_driver

Overview:
- Downstream stage of the PID controller. Converts its 8-bit saturated magnitude and sign into complementary heater/cooler PWM gate signals for the H-bridge driving the thermoelectric element.
- Latches a new command once per PWM period and inserts whole-period dead time on every direction reversal.
- Emits a period-start strobe that the system uses as the PID update/sample strobe.

Parameters:
- PRESCALE, 100: clk cycles per PWM count. Legal range 1..65535. Period = 256*PRESCALE clk cycles.
- DEADTIME_PERIODS, 2: full PWM periods with both outputs low on a direction change. Legal range 0..15.
- SLEW_STEP, 8: maximum duty increase per period. Used only when the optional feature is compiled in.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: reset, synchronous, active-high.
- en, input, 1: drive enable; low forces both outputs off.
- duty_in, input, 8: PID output magnitude; 255 means 100% on.
- dir_in, input, 1: PID sign; 1 = heat (measured below setpoint), 0 = cool.
- heat_pwm, output, 1: heater-leg gate, registered.
- cool_pwm, output, 1: cooler-leg gate, registered.
- period_tick, output, 1: one-clk pulse in the cycle pwm_cnt becomes 0.
- duty_active, output, 8: duty currently applied.
- dir_active, output, 1: direction currently applied.
- dead, output, 1: high while in DEAD state.

Behaviour:
- Reset: pre_cnt=0, pwm_cnt=0, state=IDLE, duty_active=0, dir_active=0, dead_cnt=0. All outputs 0.
- Prescaler: pre_cnt counts 0..PRESCALE-1. tick=1 when pre_cnt==PRESCALE-1.
- pwm_cnt: increments on tick and wraps 255->0. The boundary is a tick with pwm_cnt==255. period_tick is registered high for exactly the clk cycle after that boundary.
- Counters free-run in all states, including IDLE and DEAD. Only rst clears them.
- Sampling: en, duty_in and dir_in are sampled only at a boundary. Changes mid-period have no effect, except en deassertion.
- Gate compare, next-cycle registered value: on = (duty_active==255) || (pwm_cnt < duty_active).
  - heat_pwm = RUN && dir_active && on.
  - cool_pwm = RUN && !dir_active && on.
  - Output lags pwm_cnt by 1 clk.
  - duty 0 gives always low. duty 255 gives constant high, with no glitch across the wrap.
- Invariant: heat_pwm and cool_pwm are never both 1.
- State IDLE: outputs low, duty_active=0. At a boundary with en=1, go to RUN and load dir_active=dir_in and duty_active=duty_in (slew rule applies if compiled).
- State RUN, at a boundary:
  - en=0: go to IDLE.
  - dir_in!=dir_active and duty_in!=0: if DEADTIME_PERIODS==0, load the new dir/duty directly and stay in RUN. Otherwise go to DEAD, set duty_active=0, dead_cnt=DEADTIME_PERIODS.
  - Otherwise: reload duty_active. dir_active is unchanged when duty_in==0.
- State DEAD: outputs low. At each boundary dead_cnt decrements. At the boundary where dead_cnt reaches 0, go to RUN with the freshly sampled dir_in/duty_in. If en=0 at that boundary, go to IDLE instead.
- en deassert (any state, any cycle): outputs 0 on the next clk, state=IDLE, duty_active=0. Counters continue running.
- Reset mid-operation (including mid-DEAD): all state cleared on the next clk, outputs low immediately after.

Optional Feature:
- Macro: PWM_SOFTSTART_EN.
- Defined: on each load in RUN, increases are limited: duty_active = min(duty_in, duty_active+SLEW_STEP), computed 9-bit and saturated to 255. Decreases apply immediately. Entry from IDLE or DEAD starts ramping from 0.
- Undefined: duty_active = duty_in on every load. The SLEW_STEP parameter is ignored.

Test Plan:
- Reset/idle: PRESCALE=2. Hold rst 5 cycles, then en=0 for 2000 cycles -> all outputs 0. period_tick pulses every 512 clk.
- Steady heat: PRESCALE=2, en=1, duty_in=64, dir_in=1 -> from the first boundary, heat_pwm high 128 clk per 512-clk period, cool_pwm=0, duty_active=64.
- Full/zero duty: duty_in=255 -> heat_pwm continuously 1 across periods. duty_in=0 -> 0 continuously. Mid-period change from 255 to 0 only takes effect at the next boundary.
- Reversal: DEADTIME_PERIODS=2, running heat duty 100, switch dir_in=0 duty 50 -> dead=1 and both gates 0 for 1024 clk, then cool_pwm 100 clk/period. Never both high.
- Abort: en=0 mid-period while heat_pwm=1 -> heat_pwm 0 next clk, IDLE. rst asserted during DEAD -> all zero, state IDLE.
- Soft-start (PWM_SOFTSTART_EN defined, SLEW_STEP=8): duty_in 0->200 -> duty_active 8,16,...,200 over 25 boundaries. Step down to 40 -> 40 at the next boundary.

Source files
------------

// File: rtl/pwm_bridge_driver.sv
// H-bridge PWM driver: turns PID magnitude/sign into heater/cooler gates with period dead time.
// Define PWM_SOFTSTART_EN to limit per-period duty increases to SLEW_STEP.
module pwm_bridge_driver #(
   parameter int unsigned PRESCALE         = 100,
   parameter int unsigned DEADTIME_PERIODS = 2,
   parameter int unsigned SLEW_STEP        = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [7:0] duty_i,
   input  logic       dir_i,
   output logic       heat_pwm_o,
   output logic       cool_pwm_o,
   output logic       period_tick_o,
   output logic [7:0] duty_active_o,
   output logic       dir_active_o,
   output logic       dead_o
);

`ifdef PWM_SOFTSTART_EN
   localparam bit SoftStart = 1'b1;
`else
   localparam bit SoftStart = 1'b0;
`endif
   // Without soft-start a step of 255 turns the ramp limit into a pass-through.
   localparam logic [9:0] Step = SoftStart ? 10'(SLEW_STEP) : 10'd255;

   typedef enum logic [1:0] {StIdle, StRun, StDead} state_e;

   state_e      state_q;
   logic [15:0] pre_cnt_q;
   logic [7:0]  pwm_cnt_q;
   logic [7:0]  duty_q;
   logic        dir_q;
   logic [3:0]  dead_cnt_q;
   logic        heat_q;
   logic        cool_q;
   logic        tick_q;

   logic       tick;
   logic       boundary;
   logic       on;
   logic       reversal;
   logic [9:0] ramp;
   logic [7:0] load_duty;

   assign tick     = (pre_cnt_q == 16'(PRESCALE - 1));
   assign boundary = tick && (pwm_cnt_q == 8'd255);
   assign on       = (duty_q == 8'd255) || (pwm_cnt_q < duty_q);
   assign reversal = (dir_i != dir_q) && (duty_i != 8'd0);

   always_comb begin
      ramp = {2'b00, duty_q} + Step;
      if (ramp > 10'd255) begin
         ramp = 10'd255;
      end
      load_duty = ({2'b00, duty_i} < ramp) ? duty_i : ramp[7:0];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         pre_cnt_q  <= '0;
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
         dir_q      <= 1'b0;
         dead_cnt_q <= '0;
         heat_q     <= 1'b0;
         cool_q     <= 1'b0;
         tick_q     <= 1'b0;
      end else begin
         // Counters free-run regardless of state so the PID sample strobe never stalls.
         pre_cnt_q <= tick ? '0 : pre_cnt_q + 16'd1;
         if (tick) begin
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
         end
         tick_q <= boundary;
         heat_q <= en_i && (state_q == StRun) && dir_q && on;
         cool_q <= en_i && (state_q == StRun) && !dir_q && on;

         if (!en_i) begin
            state_q    <= StIdle;
            duty_q     <= '0;
            dead_cnt_q <= '0;
         end else if (boundary) begin
            unique case (state_q)
               StIdle: begin
                  state_q <= StRun;
                  dir_q   <= dir_i;
                  duty_q  <= load_duty;
               end
               StRun: begin
                  if (reversal && (DEADTIME_PERIODS != 0)) begin
                     state_q    <= StDead;
                     duty_q     <= '0;
                     dead_cnt_q <= 4'(DEADTIME_PERIODS);
                  end else begin
                     duty_q <= load_duty;
                     // A zero command keeps the last direction so it cannot force a reversal.
                     if (duty_i != 8'd0) begin
                        dir_q <= dir_i;
                     end
                  end
               end
               StDead: begin
                  dead_cnt_q <= dead_cnt_q - 4'd1;
                  if (dead_cnt_q <= 4'd1) begin
                     state_q <= StRun;
                     dir_q   <= dir_i;
                     duty_q  <= load_duty;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign heat_pwm_o    = heat_q;
   assign cool_pwm_o    = cool_q;
   assign period_tick_o = tick_q;
   assign duty_active_o = duty_q;
   assign dir_active_o  = dir_q;
   assign dead_o        = (state_q == StDead);

endmodule

// File: tb/tb_pwm_bridge_driver.sv
// Bench for pwm_bridge_driver: period-phase reference model checked every cycle, plus
// hand-computed gate-count literals per PWM period.
module tb_pwm_bridge_driver;
   localparam int P    = 2;
   localparam int DT   = 2;
   localparam int STEP = 8;
   localparam int PER  = 256 * P;
`ifdef PWM_SOFTSTART_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] duty = 8'd0;
   logic       dir = 1'b0;
   logic       heat, cool, ptick, dir_act, dead;
   logic [7:0] duty_act;

   int n_cmp = 0;
   int n_bad = 0;

   pwm_bridge_driver #(
      .PRESCALE        (P),
      .DEADTIME_PERIODS(DT),
      .SLEW_STEP       (STEP)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .en_i         (en),
      .duty_i       (duty),
      .dir_i        (dir),
      .heat_pwm_o   (heat),
      .cool_pwm_o   (cool),
      .period_tick_o(ptick),
      .duty_active_o(duty_act),
      .dir_active_o (dir_act),
      .dead_o       (dead)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: time is tracked as a cycle index within the period, not as counters.
   int   n, ph, m_mode, m_duty, m_dir, m_dead;
   bit   started = 1'b0;
   bit   bnd, on;
   logic exp_heat = 1'b0, exp_cool = 1'b0, exp_tick = 1'b0, exp_dead = 1'b0, exp_dir = 1'b0;
   logic [7:0] exp_duty = 8'd0;

   function automatic int load_val(input int req, input int cur);
      int lim;
      if (!SOFT) return req;
      lim = (cur + STEP > 255) ? 255 : cur + STEP;
      return (req < lim) ? req : lim;
   endfunction

   always @(posedge clk) begin
      started = 1'b1;
      if (rst) begin
         n = 0; m_mode = 0; m_duty = 0; m_dir = 0; m_dead = 0;
         exp_heat = 0; exp_cool = 0; exp_tick = 0; exp_dead = 0; exp_dir = 0; exp_duty = 0;
      end else begin
         ph  = n % PER;
         bnd = (ph == PER - 1);
         on  = (m_duty == 255) || (ph < m_duty * P);
         exp_heat = en && (m_mode == 1) && (m_dir == 1) && on;
         exp_cool = en && (m_mode == 1) && (m_dir == 0) && on;
         exp_tick = bnd;
         if (!en) begin
            m_mode = 0; m_duty = 0;
         end else if (bnd) begin
            case (m_mode)
               0: begin m_mode = 1; m_dir = int'(dir); m_duty = load_val(int'(duty), m_duty); end
               1: begin
                  if ((int'(dir) != m_dir) && (duty != 0)) begin
                     if (DT == 0) begin
                        m_dir = int'(dir); m_duty = load_val(int'(duty), m_duty);
                     end else begin
                        m_mode = 2; m_duty = 0; m_dead = DT;
                     end
                  end else begin
                     m_duty = load_val(int'(duty), m_duty);
                     if (duty != 0) m_dir = int'(dir);
                  end
               end
               default: begin
                  m_dead = m_dead - 1;
                  if (m_dead == 0) begin
                     m_mode = 1; m_dir = int'(dir); m_duty = load_val(int'(duty), 0);
                  end
               end
            endcase
         end
         n++;
         exp_duty = 8'(m_duty);
         exp_dir  = m_dir[0];
         exp_dead = (m_mode == 2);
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("heat_pwm", heat, exp_heat);
         chk("cool_pwm", cool, exp_cool);
         chk("period_tick", ptick, exp_tick);
         chk("duty_active", duty_act, exp_duty);
         chk("dir_active", dir_act, exp_dir);
         chk("dead", dead, exp_dead);
         chk("gates_exclusive", heat & cool, 0);
      end
   end

   task automatic wait_tick(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!ptick && k < PER + 16);
      if (!ptick) chk("tick_timeout", k, PER);
   endtask

   task automatic measure(input int cycles, output int h, output int c, output int d);
      h = 0; c = 0; d = 0;
      for (int i = 0; i < cycles; i++) begin
         h += int'(heat); c += int'(cool); d += int'(dead);
         @(negedge clk);
      end
   endtask

   task automatic settle(input int periods);
      int k;
      if (SOFT) for (int i = 0; i < periods; i++) wait_tick(k);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, h, c, d;
      repeat (5) @(negedge clk);
      chk("reset_outputs", {heat, cool, ptick, dir_act, dead, duty_act}, 0);
      rst = 1'b0;
      wait_tick(k);
      chk("first_tick_latency", k, PER);
      wait_tick(k);
      chk("tick_spacing", k, PER);
      repeat (1000) @(negedge clk);

      // Steady heat at 64/255.
      en = 1'b1; duty = 8'd64; dir = 1'b1;
      wait_tick(k);
      settle(8);
      measure(PER, h, c, d);
      chk("steady_heat_high", h, 128);
      chk("steady_cool_high", c, 0);
      chk("steady_duty_active", duty_act, 64);

      // Full duty holds across the wrap; a mid-period drop to 0 waits for the boundary.
      duty = 8'd255;
      wait_tick(k);
      settle(24);
      wait_tick(k);
      measure(100, h, c, d);
      chk("full_first_100", h, 100);
      duty = 8'd0;
      measure(PER - 100, h, c, d);
      chk("full_rest_after_mid_change", h, PER - 100);
      measure(PER, h, c, d);
      chk("zero_period_lag_only", h, 1);
      measure(PER, h, c, d);
      chk("zero_period_high", h, 0);

      // Reversal heat 100 -> cool 50 with two dead periods.
      duty = 8'd100;
      wait_tick(k);
      settle(13);
      measure(PER, h, c, d);
      chk("heat100_high", h, 200);
      dir = 1'b0; duty = 8'd50;
      measure(PER, h, c, d);
      chk("heat100_before_rev", h, 200);
      measure(2 * PER, h, c, d);
      chk("dead_cycles", d, 2 * PER);
      chk("dead_heat_high", h, 0);
      chk("dead_cool_high", c, 0);
      settle(7);
      measure(PER, h, c, d);
      chk("cool50_high", c, 100);
      chk("cool50_heat_high", h, 0);
      chk("cool50_dir_active", dir_act, 0);

      // Abort with en while heat is on.
      dir = 1'b1; duty = 8'd200;
      repeat (3) wait_tick(k);
      repeat (5) @(negedge clk);
      chk("abort_heat_before", heat, 1);
      en = 1'b0;
      @(negedge clk);
      chk("abort_heat_after", heat, 0);
      chk("abort_duty_after", duty_act, 0);

      // Reset in the middle of DEAD.
      en = 1'b1;
      wait_tick(k);
      dir = 1'b0; duty = 8'd30;
      wait_tick(k);
      repeat (300) @(negedge clk);
      chk("dead_before_rst", dead, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_in_dead_outputs", {heat, cool, ptick, dir_act, dead, duty_act}, 0);
      rst = 1'b0;
      wait_tick(k);
      chk("tick_after_rst", k, PER);
      settle(4);
      measure(PER, h, c, d);
      chk("cool30_after_rst", c, 60);

      // Ramp 0 -> 200, then a step down.
      duty = 8'd0;
      wait_tick(k);
      chk("zero_load", duty_act, 0);
      duty = 8'd200;
      for (int i = 1; i <= 25; i++) begin
         wait_tick(k);
         chk("ramp_duty", duty_act, SOFT ? 8 * i : 200);
      end
      duty = 8'd40;
      wait_tick(k);
      chk("step_down", duty_act, 40);

      repeat (10) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
